// File: rtl/abacus_counter_reader.sv
// rtl/abacus_counter_reader.sv - Wishbone classic reader that streams a block of ABACUS profiler counters
module abacus_counter_reader #(
    parameter logic [31:0] BASE_ADDR = 32'hf0030100,
    parameter int          MAX_WORDS = 16,
    parameter int          TIMEOUT   = 255,
    localparam int         IW        = $clog2(MAX_WORDS),
    localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_words,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [31:0]   wb_adr,
    input  logic [31:0]   wb_dat_i,
    input  logic          wb_ack,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [IW-1:0] out_index,
    output logic          out_last
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] N_MAX   = CW'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, OUT, FIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] n;
    logic [CW-1:0] n_clamp;
    logic [IW-1:0] index, idx_nxt;
    logic [TW-1:0] wait_cnt;
    logic [31:0]   adr_q;
    logic          load_adr;
    logic          timeout_hit;
    logic          accept;
    logic          is_last;

    assign n_clamp = (num_words > N_MAX) ? N_MAX : num_words;
    assign is_last = (CW'(index) == n - CW'(1));

    always_comb begin
        state_nxt   = state;
        idx_nxt     = index;
        load_adr    = 1'b0;
        timeout_hit = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_nxt = '0;
                    if (n_clamp == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = REQ;
                        load_adr  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (wb_ack) begin
                    state_nxt = OUT;
                end else if (wait_cnt == TO_LAST) begin
                    state_nxt   = FIN;
                    timeout_hit = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = index + IW'(1);
                        state_nxt = REQ;
                        load_adr  = 1'b1;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n        <= '0;
            index    <= '0;
            wait_cnt <= '0;
            adr_q    <= BASE_ADDR;
            out_data <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_nxt;
            index <= idx_nxt;
            if (accept) begin
                n     <= n_clamp;
                error <= 1'b0;
            end
            if (timeout_hit) begin
                error <= 1'b1;
            end
            // Address only moves when a new request begins, so an idle bus shows the last one used
            if (load_adr) begin
                adr_q <= BASE_ADDR + {{(30 - IW){1'b0}}, idx_nxt, 2'b00};
            end
            if (state != REQ) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (state == REQ && wb_ack) begin
                out_data <= wb_dat_i;
            end
        end
    end

    assign busy      = (state == REQ) || (state == OUT);
    assign done      = (state == FIN);
    assign wb_cyc    = (state == REQ);
    assign wb_stb    = (state == REQ);
    assign wb_we     = 1'b0;
    assign wb_adr    = adr_q;
    assign out_valid = (state == OUT);
    assign out_index = index;
    assign out_last  = (state == OUT) && is_last;

endmodule
